branch_update_unit: RTL
=======================

Name: branch_update_unit

Overview:
- Resolves branch outcomes coming back from the execute stage and detects mispredictions; on a misprediction, issues a one-cycle fetch flush with a redirect PC.
- Computes the next 2-bit prediction state for each branch and drives the prediction-cache write port (WAddr/Data/Instr_new_CB/WE).
- Sits directly upstream of the prediction cache's write side. A small update queue decouples execute from cache-write stalls.

Parameters:
- DEPTH, 4, update-queue entries (power of 2, ≥2).
- CNTW, 16, width of the statistics counters.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Res_Valid  in  1  a resolved branch is presented.
- Res_Ready  out  1  unit accepts the resolution this cycle.
- Res_PC  in  32  branch instruction address.
- Res_Target  in  32  computed branch target.
- Res_Taken  in  1  actual outcome.
- Res_Hit  in  1  fetch saw a valid cache hit for this PC.
- Res_CB  in  2  control bits read at fetch (don't-care if !Res_Hit).
- Res_PredPC  in  32  PPC used at fetch (meaningful if predicted taken).
- Wr_Stall  in  1  cache write port unavailable this cycle.
- WE  out  1  cache write enable.
- WAddr  out  32  cache write address (branch PC).
- Data  out  32  target written to the cache.
- Instr_new_CB  out  2  new control bits.
- Flush  out  1  one-cycle fetch flush.
- Redirect_PC  out  32  correct next PC; valid while Flush=1.
- Stat_Branches  out  CNTW  accepted resolutions, saturating.
- Stat_Mispred  out  CNTW  mispredictions, saturating.

Behaviour:
- Reset (Rst=0, asynchronous): queue empty; WE=0; Flush=0; Redirect_PC=0; WAddr/Data/Instr_new_CB=0; both counters=0.
- Accept = Res_Valid && Res_Ready.
- Res_Ready = !full || merge_hit.
- CB encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Predicted taken = Res_Hit && Res_CB[1].
- Counter step: taken saturates up at 11; not-taken saturates down at 00.
- Miss handling:
  - Miss and taken: allocate with CB=10.
  - Miss and not-taken: no cache write, no enqueue.
- Mispredict:
  - Condition: (pred_taken != Res_Taken), or (both taken && Res_PredPC != Res_Target).
  - On accept with mispredict, the next cycle drives Flush=1, Redirect_PC = Res_Taken ? Res_Target : Res_PC+4 (mod 2^32), and Stat_Mispred++.
  - Flush is exactly one cycle unless the following accept is also a mispredict.
- Every accept increments Stat_Branches. Both counters hold at all-ones.
- Queue: circular FIFO of {PC, target, CB}, DEPTH entries. Head drives WAddr/Data/Instr_new_CB combinationally; WE = !empty && !Wr_Stall. The head pops when WE=1.
- Latency: accept into an empty queue with Wr_Stall=0 gives WE=1 on the next cycle.
- Merge (stale-CB protection): if the accepted PC equals the tail entry's PC and the tail is not popping this cycle:
  - update the tail in place: CB = step(tail CB), target = Res_Target;
  - no new entry is created; the base CB is the tail's, not Res_CB.
- Tail popping this cycle with an equal PC: enqueue a new entry with base = popped entry's CB.
- Merge is allowed when full; this is how Res_Ready can be 1 while full.
- Simultaneous enqueue and pop when full is not allowed; Res_Ready follows the rule above.
- Pointers wrap modulo DEPTH. Count is held in log2(DEPTH)+1 bits.
- A mid-operation reset discards queued updates; the cache is cleared by its own reset.

Decomposition:
- Package branch_pkg holds:
  - CB encodings (CB_SNT/CB_WNT/CB_WT/CB_ST);
  - function cb_step(cb, taken);
  - the queue-entry struct typedef (pc, target, cb).
- One sub-module, update_fifo: parameterised DEPTH, with tail peek and in-place tail write. The mispredict and counter logic stay in the top level.

Test Plan:
- Reset → WE=0, Flush=0, counters 0. Miss taken PC=0x100, target 0x200 → next cycle WE=1, WAddr=0x100, Data=0x200, CB=10, Flush=1, Redirect_PC=0x200, Stat_Mispred=1.
- Hit CB=11 taken, PredPC=target=0x200 → write CB=11, Flush=0. Then hit CB=10 not-taken PC=0x100 → CB=01, Flush=1, Redirect_PC=0x104.
- Wr_Stall=1 with 4 distinct taken misses → Res_Ready=0 on the 5th distinct PC. Same PC as tail while full → accepted and merged (10→11). Release stall → 4 writes in FIFO order, WE high 4 consecutive cycles.
- Hit CB=11 taken with PredPC=0x300, target=0x400 → Flush=1, Redirect_PC=0x400, written CB=11, Data=0x400.
- Miss not-taken PC=0x500 → no WE, no Flush, Stat_Branches++.
- Rst pulsed low asynchronously mid-drain with 3 entries queued → WE drops immediately, queue empty, counters 0. Res_PC=0xFFFFFFFC not-taken mispredict → Redirect_PC=0x00000000.

Source files
------------

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types, CB encodings and counter-step helper for the branch update unit
package branch_pkg;

  localparam logic [1:0] CB_SNT = 2'b00;
  localparam logic [1:0] CB_WNT = 2'b01;
  localparam logic [1:0] CB_WT  = 2'b10;
  localparam logic [1:0] CB_ST  = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [1:0]  cb;
  } bq_entry_t;

  // Two-bit saturating counter step toward the actual outcome.
  function automatic logic [1:0] cb_step(input logic [1:0] cb, input logic taken);
    if (taken) begin
      return (cb == CB_ST) ? CB_ST : cb + 2'd1;
    end
    return (cb == CB_SNT) ? CB_SNT : cb - 2'd1;
  endfunction

endpackage

// File: rtl/update_fifo.sv
// rtl/update_fifo.sv - circular update queue with tail peek and in-place tail rewrite
module update_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  bq_entry_t     push_entry_i,
  input  logic          pop_i,
  input  logic          tail_wr_i,
  input  bq_entry_t     tail_entry_i,
  output bq_entry_t     head_o,
  output bq_entry_t     tail_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  bq_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic [AW-1:0]     tail_idx;

  assign tail_idx = wr_ptr_q - AW'(1);
  assign head_o   = mem_q[rd_ptr_q];
  assign tail_o   = mem_q[tail_idx];
  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign count_o  = count_q;

  // Storage, pointers and occupancy; a merge rewrites the newest entry without moving pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (tail_wr_i) begin
        mem_q[tail_idx] <= tail_entry_i;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

endmodule

// File: rtl/branch_update_unit.sv
// rtl/branch_update_unit.sv - resolves branches, flags mispredictions and queues prediction-cache writes
module branch_update_unit
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Res_Valid,
  output logic            Res_Ready,
  input  logic [31:0]     Res_PC,
  input  logic [31:0]     Res_Target,
  input  logic            Res_Taken,
  input  logic            Res_Hit,
  input  logic [1:0]      Res_CB,
  input  logic [31:0]     Res_PredPC,
  input  logic            Wr_Stall,
  output logic            WE,
  output logic [31:0]     WAddr,
  output logic [31:0]     Data,
  output logic [1:0]      Instr_new_CB,
  output logic            Flush,
  output logic [31:0]     Redirect_PC,
  output logic [CNTW-1:0] Stat_Branches,
  output logic [CNTW-1:0] Stat_Mispred
);

  localparam int CW = $clog2(DEPTH) + 1;

  bq_entry_t       head, tail, new_entry;
  logic            empty, full;
  logic [CW-1:0]   count;
  logic            pred_taken, mispredict, accept;
  logic            tail_match, tail_popping, merge_hit, need_write;
  logic            push, tail_wr;
  logic [1:0]      base_cb;
  logic            flush_q;
  logic [31:0]     redirect_q;
  logic [CNTW-1:0] stat_br_q, stat_mp_q;

  update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (Clk),
    .rst_ni       (Rst),
    .push_i       (push),
    .push_entry_i (new_entry),
    .pop_i        (WE),
    .tail_wr_i    (tail_wr),
    .tail_entry_i (new_entry),
    .head_o       (head),
    .tail_o       (tail),
    .empty_o      (empty),
    .full_o       (full),
    .count_o      (count)
  );

  // Resolution decode, queue-merge decision and the new cache entry.
  always_comb begin
    pred_taken   = Res_Hit && Res_CB[1];
    mispredict   = (pred_taken != Res_Taken) ||
                   (pred_taken && Res_Taken && (Res_PredPC != Res_Target));
    WE           = !empty && !Wr_Stall;
    // The newest queued entry holds a CB the cache has not seen yet, so it is the true base.
    tail_match   = !empty && (tail.pc == Res_PC);
    tail_popping = WE && (count == CW'(1));
    merge_hit    = tail_match && !tail_popping;
    Res_Ready    = !full || merge_hit;
    accept       = Res_Valid && Res_Ready;
    need_write   = Res_Hit || Res_Taken;
    base_cb      = tail_match ? tail.cb : Res_CB;
    new_entry.pc     = Res_PC;
    new_entry.target = Res_Target;
    new_entry.cb     = (tail_match || Res_Hit) ? cb_step(base_cb, Res_Taken) : CB_WT;
    push         = accept && need_write && !merge_hit;
    tail_wr      = accept && need_write && merge_hit;
  end

  assign WAddr         = head.pc;
  assign Data          = head.target;
  assign Instr_new_CB  = head.cb;
  assign Flush         = flush_q;
  assign Redirect_PC   = redirect_q;
  assign Stat_Branches = stat_br_q;
  assign Stat_Mispred  = stat_mp_q;

  // One-cycle flush with redirect, plus saturating statistics.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      stat_br_q  <= '0;
      stat_mp_q  <= '0;
    end else begin
      flush_q <= accept && mispredict;
      if (accept && mispredict) begin
        redirect_q <= Res_Taken ? Res_Target : Res_PC + 32'd4;
        if (stat_mp_q != '1) stat_mp_q <= stat_mp_q + CNTW'(1);
      end
      if (accept && stat_br_q != '1) begin
        stat_br_q <= stat_br_q + CNTW'(1);
      end
    end
  end

endmodule
